// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS-subset control FSM with mem/muldiv wait watchdogs and EXC state.
// Define MCU_PERF_CNT_EN to add cyc_cnt/ret_cnt performance counters.
module mc_control_fsm #(
  parameter int MEM_LAT_MAX = 15,
  parameter int MD_LAT_MAX  = 40,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  input  logic        div_zero,
  input  logic        mem_ready,
  input  logic        md_done,
  output logic [3:0]  state,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        epc_write,
  output logic        cause_write,
  output logic [2:0]  pc_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  reg_dst,
  output logic [2:0]  wb_src,
  output logic        md_start,
  output logic        md_op,
  output logic [1:0]  cause
`ifdef MCU_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
`endif
);
  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_JUMP, S_MD_WAIT, S_EXC
  } state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0] r_op, r_funct, w_op, w_fn;
  logic [1:0] r_cause, w_exc_cause;
  logic w_unused;
  assign w_unused = ^instr[25:6];
  // Dispatch uses the live IR in DECODE; later states use the copy latched there.
  assign w_op = (r_state == S_DECODE) ? instr[31:26] : r_op;
  assign w_fn = (r_state == S_DECODE) ? instr[5:0] : r_funct;
  logic w_r, w_add, w_sub, w_and, w_slt, w_sll, w_sra, w_jr, w_mfhi, w_mflo, w_mult, w_div;
  logic w_addi, w_lui, w_lw, w_lb, w_sw, w_sb, w_beq, w_bne, w_j, w_jal;
  logic w_alur, w_ld, w_st, w_md, w_exe, w_mem_to, w_md_to;
  assign w_r    = w_op == 6'h00;
  assign w_add  = w_r && w_fn == 6'h20;
  assign w_sub  = w_r && w_fn == 6'h22;
  assign w_and  = w_r && w_fn == 6'h24;
  assign w_slt  = w_r && w_fn == 6'h2a;
  assign w_sll  = w_r && w_fn == 6'h00;
  assign w_sra  = w_r && w_fn == 6'h03;
  assign w_jr   = w_r && w_fn == 6'h08;
  assign w_mfhi = w_r && w_fn == 6'h10;
  assign w_mflo = w_r && w_fn == 6'h12;
  assign w_mult = w_r && w_fn == 6'h18;
  assign w_div  = w_r && w_fn == 6'h1a;
  assign w_addi = w_op == 6'h08;
  assign w_lui  = w_op == 6'h0f;
  assign w_lw   = w_op == 6'h23;
  assign w_lb   = w_op == 6'h20;
  assign w_sw   = w_op == 6'h2b;
  assign w_sb   = w_op == 6'h28;
  assign w_beq  = w_op == 6'h04;
  assign w_bne  = w_op == 6'h05;
  assign w_j    = w_op == 6'h02;
  assign w_jal  = w_op == 6'h03;
  assign w_alur = w_add | w_sub | w_and | w_slt | w_sll | w_sra;
  assign w_ld   = w_lw | w_lb;
  assign w_st   = w_sw | w_sb;
  assign w_md   = w_mult | w_div;
  assign w_exe  = w_alur | w_addi | w_lui | w_md | w_ld | w_st;
  assign w_mem_to = r_cnt == CNT_W'(MEM_LAT_MAX - 1);
  assign w_md_to  = r_cnt == CNT_W'(MD_LAT_MAX - 1);
  assign state = r_state;
  assign cause = r_cause;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RESET;
      r_cnt   <= '0;
      r_op    <= '0;
      r_funct <= '0;
      r_cause <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      if (r_state == S_DECODE) begin
        r_op    <= instr[31:26];
        r_funct <= instr[5:0];
      end
      if (w_next == S_EXC) r_cause <= w_exc_cause;
    end
  end
  always_comb begin
    w_next = r_state;
    w_exc_cause = 2'b00;
    ir_write = 1'b0;
    pc_write = 1'b0;
    reg_write = 1'b0;
    epc_write = 1'b0;
    cause_write = 1'b0;
    pc_src = 3'b000;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_size = 2'b00;
    alu_op = 4'b0000;
    alu_src_b = 2'b00;
    reg_dst = 2'b00;
    wb_src = 3'b000;
    md_start = 1'b0;
    md_op = 1'b0;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        mem_size = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          alu_op = 4'b0010;
          alu_src_b = 2'b01;
          w_next = S_DECODE;
        end else if (w_mem_to) begin
          w_next = S_EXC;
          w_exc_cause = 2'b11;
        end
      end
      S_DECODE: begin
        alu_op = 4'b0010;
        alu_src_b = 2'b11;
        w_next = w_exe ? S_EXEC : (w_mfhi | w_mflo) ? S_WB : (w_beq | w_bne) ? S_BRANCH :
                 (w_j | w_jal | w_jr) ? S_JUMP : S_EXC;
        w_exc_cause = 2'b01;
      end
      S_EXEC: begin
        alu_op = w_sub ? 4'b0110 : w_and ? 4'b0001 : w_slt ? 4'b0111 : w_sll ? 4'b0100 :
                 w_sra ? 4'b0101 : w_lui ? 4'b1000 : 4'b0010;
        alu_src_b = w_r ? 2'b00 : 2'b10;
        md_op = w_div;
        md_start = w_md && !(w_div && div_zero);
        w_next = ((w_add | w_sub | w_addi) && alu_ovf) || (w_div && div_zero) ? S_EXC :
                 w_md ? S_MD_WAIT : (w_ld | w_st) ? S_MEM : S_WB;
        w_exc_cause = w_div ? 2'b10 : 2'b00;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we = w_st;
        mem_size = (w_lb | w_sb) ? 2'b00 : 2'b10;
        w_next = mem_ready ? (w_ld ? S_WB : S_FETCH) : w_mem_to ? S_EXC : S_MEM;
        w_exc_cause = 2'b11;
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst = (w_alur | w_mfhi | w_mflo) ? 2'b01 : 2'b00;
        wb_src = w_ld ? 3'b001 : w_mfhi ? 3'b011 : w_mflo ? 3'b100 : 3'b000;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_op = 4'b0110;
        pc_write = w_beq ? alu_zero : !alu_zero;
        pc_src = 3'b001;
        w_next = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src = w_jr ? 3'b011 : 3'b010;
        reg_write = w_jal;
        reg_dst = w_jal ? 2'b10 : 2'b00;
        wb_src = w_jal ? 3'b010 : 3'b000;
        w_next = S_FETCH;
      end
      S_MD_WAIT: begin
        md_op = w_div;
        w_next = md_done ? S_FETCH : w_md_to ? S_EXC : S_MD_WAIT;
        w_exc_cause = 2'b11;
      end
      S_EXC: begin
        epc_write = 1'b1;
        cause_write = 1'b1;
        pc_write = 1'b1;
        pc_src = 3'b100;
        w_next = S_FETCH;
      end
      default: w_next = S_RESET;
    endcase
  end
`ifdef MCU_PERF_CNT_EN
  logic [31:0] r_cyc, r_ret;
  assign cyc_cnt = r_cyc;
  assign ret_cnt = r_ret;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc <= '0;
      r_ret <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (w_next == S_FETCH && r_state != S_FETCH && r_state != S_EXC && r_state != S_RESET)
        r_ret <= r_ret + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed scenario tasks for the multicycle control FSM.
module tb_mc_control_fsm;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] instr = '0;
  logic alu_zero = 0, alu_ovf = 0, div_zero = 0, mem_ready = 0, md_done = 0;
  logic [3:0] state, alu_op;
  logic ir_write, pc_write, reg_write, epc_write, cause_write, mem_req, mem_we, md_start, md_op;
  logic [2:0] pc_src, wb_src;
  logic [1:0] mem_size, alu_src_b, reg_dst, cause;
  logic [26:0] all_o;
  int total = 0, bad = 0;
  localparam logic [3:0] ST_RESET = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_EXEC = 4'd3,
    ST_MEM = 4'd4, ST_WB = 4'd5, ST_BRANCH = 4'd6, ST_JUMP = 4'd7, ST_MDW = 4'd8, ST_EXC = 4'd9;
  localparam logic [31:0] I_ADD = 32'h00221820, I_LW = 32'h8C220004, I_DIV = 32'h0022001A,
    I_MULT = 32'h00220018, I_BEQ = 32'h10220003, I_BNE = 32'h14220003, I_BAD = 32'hFC000000,
    I_JAL = 32'h0C000010, I_SB = 32'hA0220004, I_MFHI = 32'h00001810;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .div_zero(div_zero), .mem_ready(mem_ready), .md_done(md_done), .state(state),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .epc_write(epc_write),
    .cause_write(cause_write), .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we),
    .mem_size(mem_size), .alu_op(alu_op), .alu_src_b(alu_src_b), .reg_dst(reg_dst),
    .wb_src(wb_src), .md_start(md_start), .md_op(md_op), .cause(cause)
  );

  always #5 clk = ~clk;
  assign all_o = {ir_write, pc_write, reg_write, epc_write, cause_write, pc_src, mem_req, mem_we,
                  mem_size, alu_op, alu_src_b, reg_dst, wb_src, md_start, md_op, cause};

  // Drives one FETCH cycle with mem_ready and leaves the bench in DECODE, #1 after negedge.
  task automatic fetch(input logic [31:0] ins);
    instr = ins;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
  endtask

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if ({state, all_o} !== {ST_RESET, 27'd0}) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=%h", {state, all_o}, {ST_RESET, 27'd0});
    end
    reset = 1'b0;
    next_cyc();
    total++;
    if (state !== ST_FETCH) begin
      bad++;
      $display("FAIL reset_to_fetch got=%0d want=%0d", state, ST_FETCH);
    end
  endtask

  task automatic test_add();
    instr = I_ADD;
    mem_ready = 1'b1;
    #1;
    total++;
    if ({state, ir_write, pc_write, pc_src, alu_src_b, mem_req, mem_size} !==
        {ST_FETCH, 1'b1, 1'b1, 3'b000, 2'b01, 1'b1, 2'b10}) begin
      bad++;
      $display("FAIL add_fetch got=%h want=%h",
               {state, ir_write, pc_write, pc_src, alu_src_b, mem_req, mem_size},
               {ST_FETCH, 1'b1, 1'b1, 3'b000, 2'b01, 1'b1, 2'b10});
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    total++;
    if ({state, alu_op, alu_src_b} !== {ST_DECODE, 4'b0010, 2'b11}) begin
      bad++;
      $display("FAIL add_decode got=%h want=%h", {state, alu_op, alu_src_b}, {ST_DECODE, 4'b0010, 2'b11});
    end
    next_cyc();
    total++;
    if ({state, alu_op, alu_src_b, reg_write} !== {ST_EXEC, 4'b0010, 2'b00, 1'b0}) begin
      bad++;
      $display("FAIL add_exec got=%h want=%h", {state, alu_op, alu_src_b, reg_write},
               {ST_EXEC, 4'b0010, 2'b00, 1'b0});
    end
    next_cyc();
    total++;
    if ({state, reg_write, reg_dst, wb_src} !== {ST_WB, 1'b1, 2'b01, 3'b000}) begin
      bad++;
      $display("FAIL add_wb got=%h want=%h", {state, reg_write, reg_dst, wb_src}, {ST_WB, 1'b1, 2'b01, 3'b000});
    end
    next_cyc();
    total++;
    if (state !== ST_FETCH) begin
      bad++;
      $display("FAIL add_back_fetch got=%0d want=%0d", state, ST_FETCH);
    end
  endtask

  task automatic test_bad_op();
    fetch(I_BAD);
    next_cyc();
    total++;
    if ({state, cause, epc_write} !== {ST_EXC, 2'b01, 1'b1}) begin
      bad++;
      $display("FAIL badop_exc got=%h want=%h", {state, cause, epc_write}, {ST_EXC, 2'b01, 1'b1});
    end
    next_cyc();
    total++;
    if ({state, cause} !== {ST_FETCH, 2'b01}) begin
      bad++;
      $display("FAIL badop_cause_held got=%h want=%h", {state, cause}, {ST_FETCH, 2'b01});
    end
  endtask

  task automatic test_add_ovf();
    fetch(I_ADD);
    @(negedge clk);
    alu_ovf = 1'b1;
    #1;
    total++;
    if ({state, reg_write} !== {ST_EXEC, 1'b0}) begin
      bad++;
      $display("FAIL ovf_exec got=%h want=%h", {state, reg_write}, {ST_EXEC, 1'b0});
    end
    @(negedge clk);
    alu_ovf = 1'b0;
    #1;
    total++;
    if ({state, reg_write, epc_write, cause_write, pc_write, pc_src, cause} !==
        {ST_EXC, 1'b0, 1'b1, 1'b1, 1'b1, 3'b100, 2'b00}) begin
      bad++;
      $display("FAIL ovf_exc got=%h want=%h",
               {state, reg_write, epc_write, cause_write, pc_write, pc_src, cause},
               {ST_EXC, 1'b0, 1'b1, 1'b1, 1'b1, 3'b100, 2'b00});
    end
    next_cyc();
    total++;
    if (state !== ST_FETCH) begin
      bad++;
      $display("FAIL ovf_back_fetch got=%0d want=%0d", state, ST_FETCH);
    end
  endtask

  // ready_last: assert mem_ready on the 15th MEM cycle instead of never.
  task automatic test_lw(input logic ready_last);
    fetch(I_LW);
    next_cyc();
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      mem_ready = ready_last && (i == 14);
      #1;
      total++;
      if ({state, mem_req, mem_we, mem_size} !== {ST_MEM, 1'b1, 1'b0, 2'b10}) begin
        bad++;
        $display("FAIL lw_mem cyc=%0d got=%h want=%h", i, {state, mem_req, mem_we, mem_size},
                 {ST_MEM, 1'b1, 1'b0, 2'b10});
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    #1;
    if (ready_last) begin
      total++;
      if ({state, reg_write, wb_src, reg_dst} !== {ST_WB, 1'b1, 3'b001, 2'b00}) begin
        bad++;
        $display("FAIL lw_ready15_wb got=%h want=%h", {state, reg_write, wb_src, reg_dst},
                 {ST_WB, 1'b1, 3'b001, 2'b00});
      end
    end else begin
      total++;
      if ({state, cause} !== {ST_EXC, 2'b11}) begin
        bad++;
        $display("FAIL lw_timeout got=%h want=%h", {state, cause}, {ST_EXC, 2'b11});
      end
    end
    next_cyc();
    total++;
    if (state !== ST_FETCH) begin
      bad++;
      $display("FAIL lw_back_fetch got=%0d want=%0d", state, ST_FETCH);
    end
  endtask

  task automatic test_div();
    fetch(I_DIV);
    next_cyc();
    total++;
    if ({state, md_start, md_op} !== {ST_EXEC, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL div_start got=%h want=%h", {state, md_start, md_op}, {ST_EXEC, 1'b1, 1'b1});
    end
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      md_done = (i == 9);
      #1;
      total++;
      if ({state, md_start} !== {ST_MDW, 1'b0}) begin
        bad++;
        $display("FAIL div_wait cyc=%0d got=%h want=%h", i, {state, md_start}, {ST_MDW, 1'b0});
      end
      @(negedge clk);
    end
    md_done = 1'b0;
    #1;
    total++;
    if (state !== ST_FETCH) begin
      bad++;
      $display("FAIL div_done_fetch got=%0d want=%0d", state, ST_FETCH);
    end
    fetch(I_DIV);
    @(negedge clk);
    div_zero = 1'b1;
    #1;
    total++;
    if ({state, md_start} !== {ST_EXEC, 1'b0}) begin
      bad++;
      $display("FAIL divzero_nostart got=%h want=%h", {state, md_start}, {ST_EXEC, 1'b0});
    end
    @(negedge clk);
    div_zero = 1'b0;
    #1;
    total++;
    if ({state, cause} !== {ST_EXC, 2'b10}) begin
      bad++;
      $display("FAIL divzero_exc got=%h want=%h", {state, cause}, {ST_EXC, 2'b10});
    end
    next_cyc();
  endtask

  task automatic test_branch();
    fetch(I_BEQ);
    @(negedge clk);
    alu_zero = 1'b0;
    #1;
    total++;
    if ({state, pc_write, alu_op} !== {ST_BRANCH, 1'b0, 4'b0110}) begin
      bad++;
      $display("FAIL beq_nottaken got=%h want=%h", {state, pc_write, alu_op}, {ST_BRANCH, 1'b0, 4'b0110});
    end
    next_cyc();
    fetch(I_BNE);
    next_cyc();
    total++;
    if ({state, pc_write, pc_src} !== {ST_BRANCH, 1'b1, 3'b001}) begin
      bad++;
      $display("FAIL bne_taken got=%h want=%h", {state, pc_write, pc_src}, {ST_BRANCH, 1'b1, 3'b001});
    end
    next_cyc();
    total++;
    if (state !== ST_FETCH) begin
      bad++;
      $display("FAIL branch_back_fetch got=%0d want=%0d", state, ST_FETCH);
    end
  endtask

  task automatic test_misc();
    fetch(I_JAL);
    next_cyc();
    total++;
    if ({state, pc_write, pc_src, reg_write, reg_dst, wb_src} !==
        {ST_JUMP, 1'b1, 3'b010, 1'b1, 2'b10, 3'b010}) begin
      bad++;
      $display("FAIL jal got=%h want=%h", {state, pc_write, pc_src, reg_write, reg_dst, wb_src},
               {ST_JUMP, 1'b1, 3'b010, 1'b1, 2'b10, 3'b010});
    end
    next_cyc();
    fetch(I_MFHI);
    next_cyc();
    total++;
    if ({state, reg_write, reg_dst, wb_src} !== {ST_WB, 1'b1, 2'b01, 3'b011}) begin
      bad++;
      $display("FAIL mfhi got=%h want=%h", {state, reg_write, reg_dst, wb_src}, {ST_WB, 1'b1, 2'b01, 3'b011});
    end
    next_cyc();
    fetch(I_SB);
    next_cyc();
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    total++;
    if ({state, mem_req, mem_we, mem_size} !== {ST_MEM, 1'b1, 1'b1, 2'b00}) begin
      bad++;
      $display("FAIL sb_mem got=%h want=%h", {state, mem_req, mem_we, mem_size}, {ST_MEM, 1'b1, 1'b1, 2'b00});
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    total++;
    if (state !== ST_FETCH) begin
      bad++;
      $display("FAIL sb_back_fetch got=%0d want=%0d", state, ST_FETCH);
    end
  endtask

  task automatic test_reset_mdwait();
    fetch(I_MULT);
    next_cyc();
    next_cyc();
    next_cyc();
    total++;
    if (state !== ST_MDW) begin
      bad++;
      $display("FAIL mult_wait got=%0d want=%0d", state, ST_MDW);
    end
    reset = 1'b1;
    next_cyc();
    total++;
    if ({state, all_o} !== {ST_RESET, 27'd0}) begin
      bad++;
      $display("FAIL reset_mdwait got=%h want=%h", {state, all_o}, {ST_RESET, 27'd0});
    end
    reset = 1'b0;
    next_cyc();
    total++;
    if (state !== ST_FETCH) begin
      bad++;
      $display("FAIL reset_mdwait_fetch got=%0d want=%0d", state, ST_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_bad_op();
    test_add_ovf();
    test_lw(1'b0);
    test_lw(1'b1);
    test_div();
    test_branch();
    test_misc();
    test_reset_mdwait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
